// File: rtl/instr_encoder.sv
// Sequential MIPS instruction encoder: turns symbolic commands into 32-bit words
// and streams them into instruction memory at consecutive word addresses.
module instr_encoder #(
   parameter int AW    = 10,
   parameter int DEPTH = 1024
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic          stop,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [4:0]    in_mnem,
   input  logic [4:0]    in_rs,
   input  logic [4:0]    in_rt,
   input  logic [4:0]    in_rd,
   input  logic [4:0]    in_shamt,
   input  logic [25:0]   in_imm,
   output logic          im_valid,
   input  logic          im_ready,
   output logic [AW-1:0] im_addr,
   output logic [31:0]   im_wdata,
   output logic          busy,
   output logic          full,
   output logic          err,
   output logic [AW:0]   wr_count
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL} state_t;
   typedef enum logic [2:0] {K_R, K_RSH, K_JR, K_I, K_LUI, K_J, K_ILL} kind_t;

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   state_t        state_q, state_d;
   logic [AW-1:0] addr_cnt_q, addr_cnt_d;
   logic [AW:0]   wr_count_q, wr_count_d;
   logic          full_q, full_d;
   logic          err_q, err_d;
   logic          im_valid_q, im_valid_d;
   logic [AW-1:0] im_addr_q, im_addr_d;
   logic [31:0]   im_wdata_q, im_wdata_d;

   kind_t         kind;
   logic [5:0]    code6;
   logic [31:0]   enc_word;
   logic          in_ready_c;
   logic [AW:0]   accepted_total;

   // code6 is the R-type func field or the I/J-type opcode, depending on kind.
   always_comb begin
      kind  = K_ILL;
      code6 = 6'h00;
      case (in_mnem)
         5'd0:    begin kind = K_R;   code6 = 6'h20; end
         5'd1:    begin kind = K_R;   code6 = 6'h21; end
         5'd2:    begin kind = K_R;   code6 = 6'h22; end
         5'd3:    begin kind = K_R;   code6 = 6'h23; end
         5'd4:    begin kind = K_R;   code6 = 6'h24; end
         5'd5:    begin kind = K_R;   code6 = 6'h25; end
         5'd6:    begin kind = K_R;   code6 = 6'h26; end
         5'd7:    begin kind = K_R;   code6 = 6'h27; end
         5'd8:    begin kind = K_R;   code6 = 6'h2A; end
         5'd9:    begin kind = K_R;   code6 = 6'h2B; end
         5'd10:   begin kind = K_RSH; code6 = 6'h00; end
         5'd11:   begin kind = K_RSH; code6 = 6'h02; end
         5'd12:   begin kind = K_RSH; code6 = 6'h03; end
         5'd13:   begin kind = K_R;   code6 = 6'h04; end
         5'd14:   begin kind = K_R;   code6 = 6'h06; end
         5'd15:   begin kind = K_R;   code6 = 6'h07; end
         5'd16:   begin kind = K_JR;  code6 = 6'h08; end
         5'd17:   begin kind = K_I;   code6 = 6'h08; end
         5'd18:   begin kind = K_I;   code6 = 6'h09; end
         5'd19:   begin kind = K_I;   code6 = 6'h0C; end
         5'd20:   begin kind = K_I;   code6 = 6'h0D; end
         5'd21:   begin kind = K_I;   code6 = 6'h0E; end
         5'd22:   begin kind = K_I;   code6 = 6'h23; end
         5'd23:   begin kind = K_I;   code6 = 6'h2B; end
         5'd24:   begin kind = K_I;   code6 = 6'h04; end
         5'd25:   begin kind = K_I;   code6 = 6'h05; end
         5'd26:   begin kind = K_I;   code6 = 6'h0A; end
         5'd27:   begin kind = K_I;   code6 = 6'h0B; end
         5'd28:   begin kind = K_LUI; code6 = 6'h0F; end
         5'd29:   begin kind = K_J;   code6 = 6'h02; end
         5'd30:   begin kind = K_J;   code6 = 6'h03; end
         default: begin kind = K_ILL; code6 = 6'h00; end
      endcase
   end

   always_comb begin
      enc_word = '0;
      case (kind)
         K_R:     enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, code6};
         K_RSH:   enc_word = {6'h00, in_rs, in_rt, in_rd, in_shamt, code6};
         K_JR:    enc_word = {6'h00, in_rs, 15'd0, code6};
         K_I:     enc_word = {code6, in_rs, in_rt, in_imm[15:0]};
         K_LUI:   enc_word = {code6, 5'd0, in_rt, in_imm[15:0]};
         K_J:     enc_word = {code6, in_imm};
         default: enc_word = '0;
      endcase
   end

   // Words accepted so far, including the one waiting in the output register.
   assign accepted_total = wr_count_q + {{AW{1'b0}}, im_valid_q};

   always_comb begin
      state_d    = state_q;
      addr_cnt_d = addr_cnt_q;
      wr_count_d = wr_count_q;
      full_d     = full_q;
      err_d      = err_q;
      im_valid_d = im_valid_q;
      im_addr_d  = im_addr_q;
      im_wdata_d = im_wdata_q;
      in_ready_c = 1'b0;

      if (im_valid_q && im_ready) begin
         im_valid_d = 1'b0;
         wr_count_d = wr_count_q + 1'b1;
         if (wr_count_d == DEPTH_C) full_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_RUN;
               addr_cnt_d = base_addr;
               wr_count_d = '0;
               full_d     = 1'b0;
               err_d      = 1'b0;
            end
         end
         S_RUN: begin
            in_ready_c = (!im_valid_q || im_ready) && (accepted_total < DEPTH_C);
            if (stop)                         state_d = S_IDLE;
            else if (wr_count_d == DEPTH_C)   state_d = S_FULL;
         end
         S_FULL: begin
            if (stop) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A drain and a new accept in the same cycle simply reload the output register.
      if (in_valid && in_ready_c) begin
         if (kind != K_ILL) begin
            im_valid_d = 1'b1;
            im_wdata_d = enc_word;
            im_addr_d  = addr_cnt_q;
            addr_cnt_d = addr_cnt_q + 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         addr_cnt_q <= '0;
         wr_count_q <= '0;
         full_q     <= 1'b0;
         err_q      <= 1'b0;
         im_valid_q <= 1'b0;
         im_addr_q  <= '0;
         im_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_cnt_q <= addr_cnt_d;
         wr_count_q <= wr_count_d;
         full_q     <= full_d;
         err_q      <= err_d;
         im_valid_q <= im_valid_d;
         im_addr_q  <= im_addr_d;
         im_wdata_q <= im_wdata_d;
      end
   end

   assign in_ready = in_ready_c;
   assign im_valid = im_valid_q;
   assign im_addr  = im_addr_q;
   assign im_wdata = im_wdata_q;
   assign busy     = (state_q != S_IDLE);
   assign full     = full_q;
   assign err      = err_q;
   assign wr_count = wr_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: encoding table plus handshake, stall,
// illegal-mnemonic, DEPTH/wrap and mid-session reset sequences.
module tb_instr_encoder;

   localparam int AW    = 10;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, stop, in_valid, in_ready, im_valid, im_ready;
   logic [AW-1:0] base_addr, im_addr;
   logic [4:0]    in_mnem, in_rs, in_rt, in_rd, in_shamt;
   logic [25:0]   in_imm;
   logic [31:0]   im_wdata;
   logic          busy, full, err;
   logic [AW:0]   wr_count;

   instr_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .stop(stop),
      .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem), .in_rs(in_rs),
      .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
      .im_valid(im_valid), .im_ready(im_ready), .im_addr(im_addr), .im_wdata(im_wdata),
      .busy(busy), .full(full), .err(err), .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  mnem, rs, rt, rd, shamt;
      logic [25:0] imm;
   } cmd_t;

   typedef struct {
      cmd_t        cmd;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      int            cyc;
   } wr_t;

   wr_t wq[$];
   int  cyc = 0;
   int  n_checks = 0;
   int  n_fail = 0;

   // Completed memory writes, observed half a cycle before the edge that retires them.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (rst_n && im_valid && im_ready) wq.push_back('{im_addr, im_wdata, cyc});
   end

   function automatic cmd_t mk(input int m, input int rs, input int rt, input int rd,
                               input int sh, input logic [25:0] imm);
      cmd_t c;
      c.mnem = 5'(m); c.rs = 5'(rs); c.rt = 5'(rt); c.rd = 5'(rd); c.shamt = 5'(sh);
      c.imm = imm;
      return c;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_start(input logic [AW-1:0] base);
      start = 1'b1; base_addr = base;
      tick();
      start = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   // Presents a command and returns just after the edge that accepted it; in_valid stays high.
   task automatic send_cmd(input cmd_t c, input string name);
      bit ok = 1'b0;
      in_mnem = c.mnem; in_rs = c.rs; in_rt = c.rt; in_rd = c.rd;
      in_shamt = c.shamt; in_imm = c.imm; in_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) check({name, " accept timeout"}, 32'd0, 32'd1);
      tick();
   endtask

   task automatic check_write(input int idx, input string name,
                              input logic [AW-1:0] ea, input logic [31:0] ed);
      check({name, " write count"}, (wq.size() > idx) ? 32'd1 : 32'd0, 32'd1);
      if (wq.size() > idx) begin
         check({name, " addr"}, 32'(wq[idx].addr), 32'(ea));
         check({name, " data"}, wq[idx].data, ed);
      end
   endtask

   vec_t vt[16];
   int   b;

   initial begin
      vt[0]  = '{mk(2, 1, 2, 3, 7, 26'd0),          32'h00221822};  // sub, shamt masked
      vt[1]  = '{mk(4, 31, 31, 31, 0, 26'd0),       32'h03FFF824};  // and
      vt[2]  = '{mk(7, 5, 6, 7, 0, 26'd0),          32'h00A63827};  // nor
      vt[3]  = '{mk(9, 2, 3, 1, 0, 26'd0),          32'h0043082B};  // sltu
      vt[4]  = '{mk(12, 0, 9, 10, 31, 26'd0),       32'h000957C3};  // sra
      vt[5]  = '{mk(14, 4, 5, 6, 3, 26'd0),         32'h00853006};  // srlv, shamt masked
      vt[6]  = '{mk(16, 31, 5, 6, 2, 26'd0),        32'h03E00008};  // jr
      vt[7]  = '{mk(18, 29, 29, 0, 0, 26'h2AAFFF8), 32'h27BDFFF8};  // addiu
      vt[8]  = '{mk(22, 8, 9, 0, 0, 26'h0004),      32'h8D090004};  // lw
      vt[9]  = '{mk(28, 5, 7, 0, 0, 26'hBEEF),      32'h3C07BEEF};  // lui, rs masked
      vt[10] = '{mk(27, 1, 2, 0, 0, 26'h8000),      32'h2C228000};  // sltiu
      vt[11] = '{mk(29, 0, 0, 0, 0, 26'h3FFFFFF),   32'h0BFFFFFF};  // j
      vt[12] = '{mk(25, 1, 0, 0, 0, 26'hFFFE),      32'h1420FFFE};  // bne
      vt[13] = '{mk(26, 2, 3, 0, 0, 26'h0001),      32'h28430001};  // slti
      vt[14] = '{mk(11, 0, 1, 2, 1, 26'd0),         32'h00011042};  // srl
      vt[15] = '{mk(6, 1, 1, 1, 0, 26'd0),          32'h00210826};  // xor

      rst_n = 1'b0; start = 1'b0; stop = 1'b0; base_addr = '0; in_valid = 1'b0;
      in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0;
      im_ready = 1'b0;
      tick(); tick();
      @(negedge clk);
      check("rst in_ready", 32'(in_ready), 0);
      check("rst im_valid", 32'(im_valid), 0);
      check("rst im_addr", 32'(im_addr), 0);
      check("rst im_wdata", im_wdata, 0);
      check("rst busy", 32'(busy), 0);
      check("rst full", 32'(full), 0);
      check("rst err", 32'(err), 0);
      check("rst wr_count", 32'(wr_count), 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Encoding table: one single-word session per vector.
      im_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         b = wq.size();
         do_start(AW'(10'h080 + i));
         send_cmd(vt[i].cmd, $sformatf("vec%0d", i));
         in_valid = 1'b0;
         tick();
         @(negedge clk);
         check_write(b, $sformatf("vec%0d", i), AW'(10'h080 + i), vt[i].exp);
         tick();
         do_stop();
      end

      // Single add: one-cycle latency, then retired.
      b = wq.size();
      do_start(10'h010);
      send_cmd(mk(0, 1, 2, 3, 0, 26'd0), "add");
      in_valid = 1'b0;
      @(negedge clk);
      check("add im_valid", 32'(im_valid), 1);
      check("add im_addr", 32'(im_addr), 32'h010);
      check("add im_wdata", im_wdata, 32'h00221820);
      check("add busy", 32'(busy), 1);
      tick();
      @(negedge clk);
      check("add wr_count", 32'(wr_count), 1);
      tick();
      do_stop();

      // Back-to-back stream at full throughput.
      b = wq.size();
      do_start(10'h010);
      send_cmd(mk(10, 0, 2, 4, 5, 26'd0), "sll");
      send_cmd(mk(28, 0, 7, 0, 0, 26'h1234), "lui");
      send_cmd(mk(30, 0, 0, 0, 0, 26'h0000040), "jal");
      in_valid = 1'b0;
      tick(); tick();
      @(negedge clk);
      check("b2b wr_count", 32'(wr_count), 3);
      check_write(b, "b2b sll", 10'h010, 32'h00022140);
      check_write(b + 1, "b2b lui", 10'h011, 32'h3C071234);
      check_write(b + 2, "b2b jal", 10'h012, 32'h0C000040);
      if (wq.size() > b + 2) begin
         check("b2b gap1", 32'(wq[b+1].cyc - wq[b].cyc), 1);
         check("b2b gap2", 32'(wq[b+2].cyc - wq[b+1].cyc), 1);
      end
      tick();
      do_stop();

      // Memory stall: second command waits, first word held stable.
      b = wq.size();
      do_start(10'h020);
      im_ready = 1'b0;
      send_cmd(mk(1, 4, 5, 6, 0, 26'd0), "addu");
      in_mnem = 5'd23; in_rs = 5'd29; in_rt = 5'd8; in_imm = 26'hFFFC;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("stall in_ready %0d", k), 32'(in_ready), 0);
         check($sformatf("stall im_valid %0d", k), 32'(im_valid), 1);
         check($sformatf("stall im_addr %0d", k), 32'(im_addr), 32'h020);
         check($sformatf("stall im_wdata %0d", k), im_wdata, 32'h00853021);
         tick();
      end
      im_ready = 1'b1;
      send_cmd(mk(23, 29, 8, 0, 0, 26'hFFFC), "sw");
      in_valid = 1'b0;
      tick();
      @(negedge clk);
      check_write(b, "stall addu", 10'h020, 32'h00853021);
      check_write(b + 1, "stall sw", 10'h021, 32'hAFA8FFFC);
      check("stall wr_count", 32'(wr_count), 2);
      tick();
      do_stop();

      // Illegal mnemonic between two legal commands.
      b = wq.size();
      do_start(10'h030);
      send_cmd(mk(20, 1, 2, 0, 0, 26'h00FF), "ori");
      send_cmd(mk(31, 1, 2, 3, 4, 26'h1234), "illegal");
      send_cmd(mk(24, 3, 4, 0, 0, 26'hFFFF), "beq");
      in_valid = 1'b0;
      tick();
      @(negedge clk);
      check("ill err", 32'(err), 1);
      check("ill wr_count", 32'(wr_count), 2);
      check_write(b, "ill ori", 10'h030, 32'h342200FF);
      check_write(b + 1, "ill beq", 10'h031, 32'h1064FFFF);
      check("ill no extra write", 32'(wq.size() - b), 2);
      tick();
      do_stop();

      // DEPTH limit with address wrap.
      b = wq.size();
      do_start(10'h3FE);
      @(negedge clk);
      check("wrap err cleared", 32'(err), 0);
      tick();
      for (int i = 0; i < DEPTH; i++) send_cmd(vt[i].cmd, $sformatf("wrap%0d", i));
      in_mnem = vt[4].cmd.mnem;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("full in_ready %0d", k), 32'(in_ready), 0);
         tick();
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("full flag", 32'(full), 1);
      check("full busy", 32'(busy), 1);
      check("full wr_count", 32'(wr_count), DEPTH);
      check("full writes", 32'(wq.size() - b), DEPTH);
      check_write(b, "wrap0", 10'h3FE, vt[0].exp);
      check_write(b + 1, "wrap1", 10'h3FF, vt[1].exp);
      check_write(b + 2, "wrap2", 10'h000, vt[2].exp);
      check_write(b + 3, "wrap3", 10'h001, vt[3].exp);
      tick();
      do_stop();
      @(negedge clk);
      check("stop busy", 32'(busy), 0);
      tick();

      // Reset while a word is pending, then a clean session.
      im_ready = 1'b0;
      do_start(10'h100);
      send_cmd(mk(0, 1, 2, 3, 0, 26'd0), "pre-rst add");
      in_valid = 1'b0;
      @(negedge clk);
      check("prerst im_valid", 32'(im_valid), 1);
      rst_n = 1'b0;
      tick();
      @(negedge clk);
      check("midrst im_valid", 32'(im_valid), 0);
      check("midrst busy", 32'(busy), 0);
      check("midrst wr_count", 32'(wr_count), 0);
      check("midrst im_addr", 32'(im_addr), 0);
      rst_n = 1'b1;
      tick();
      im_ready = 1'b1;
      b = wq.size();
      do_start(10'h040);
      send_cmd(mk(0, 1, 2, 3, 0, 26'd0), "post-rst add");
      in_valid = 1'b0;
      tick();
      @(negedge clk);
      check_write(b, "postrst", 10'h040, 32'h00221820);
      check("postrst wr_count", 32'(wr_count), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
